tour_move_sequencer: RTL and testbench
======================================

// Module: tour_move_sequencer
// PURPOSE
//  Consumer end of the knight-tour solver's move readout. On a start pulse it walks indx 0..NUM_MOVES-1,
//  reads each one-hot move, and splits it into two straight-line legs: the Y leg first, then the X leg.
//  Each leg is issued as a 16-bit command to the motion controller over a valid/ack handshake.
//  It waits for leg completion before issuing the next leg. Sits between the tour solver and the command path.
// PARAMETERS
//  NUM_MOVES  24     moves read per tour (indx 0..NUM_MOVES-1)
//  MOVE_OP    4'h2   opcode for first (Y) leg: plain move
//  FANF_OP    4'h3   opcode for second (X) leg: move with fanfare (end of knight move)
// PORTS
//  clk        in   1   system clock, all logic on rising edge
//  rst        in   1   asynchronous active-high reset
//  start      in   1   1-clk pulse: solution ready (solver done); ignored unless IDLE
//  indx       out  5   move index presented to solver; move[] read combinationally same cycle
//  move       in   8   one-hot move for indx
//  cmd        out  16  {opcode[15:12], heading[11:4], squares[3:0]}
//  cmd_vld    out  1   cmd valid; held with cmd stable until cmd_ack
//  cmd_ack    in   1   1-clk pulse: downstream accepted cmd
//  leg_done   in   1   1-clk pulse: issued leg finished executing
//  busy       out  1   high in every state except IDLE
//  tour_done  out  1   1-clk pulse after last leg of last move completes
//  err        out  1   1-clk pulse when latched move is not one-hot; sequence aborts
// BEHAVIOUR
//  Reset: state=IDLE; indx=0; cmd=0; cmd_vld=0; busy=0; tour_done=0; err=0; move latch=0.
//  Reset mid-operation aborts immediately. No cmd_vld, tour_done or err after reset.
//  Move decode by bit number (dx,dy): b0(-1,+2) b1(+1,+2) b2(-2,+1) b3(-2,-1)
//   b4(-1,-2) b5(+1,-2) b6(+2,+1) b7(+2,-1).
//  Heading encoding: +Y=8'h00, -X=8'h3F, -Y=8'h7F, +X=8'hBF. squares = |offset|, zero-extended to 4b.
//  Y-leg cmd = {MOVE_OP, hdg(dy), |dy|}. X-leg cmd = {FANF_OP, hdg(dx), |dx|}.
//  FSM:
//   IDLE:  start -> indx<=0, LOAD.
//   LOAD:  latch move[indx]. If not one-hot (incl. 0): pulse err, go IDLE, indx<=0.
//          Otherwise load Y-leg cmd, cmd_vld<=1, go YCMD.
//   YCMD:  hold cmd_vld until cmd_ack. On ack: cmd_vld<=0 next edge, go YWAIT.
//   YWAIT: leg_done -> load X-leg cmd, cmd_vld<=1, go XCMD.
//   XCMD:  as YCMD, then go XWAIT.
//   XWAIT: leg_done -> if indx==NUM_MOVES-1, pulse tour_done and go IDLE with indx<=0;
//          else indx<=indx+1 and go LOAD.
//  Latency: start -> first cmd_vld = 2 clks (IDLE->LOAD->YCMD visible).
//   leg_done -> next cmd_vld = 1 clk within a move, 2 clks across moves.
//  cmd and the move latch change only on LOAD or a WAIT->CMD transition; stable while cmd_vld=1.
//  leg_done outside a WAIT state is ignored. cmd_ack outside a CMD state is ignored.
//  cmd_ack and leg_done in the same cycle in a CMD state: ack is taken, leg_done is dropped.
//  start while busy is ignored. indx never exceeds NUM_MOVES-1 (no wrap).
//  busy falls in the same cycle tour_done/err is seen, i.e. the edge entering IDLE.
// TESTING
//  1) start, move=8'h01 at all indx, ack 1 clk after vld, leg_done 3 clks after ack
//     -> cmds 16'h2002, 16'h33F1 alternate; 48 cmds; tour_done 1 pulse; indx 0..23.
//  2) move=8'h80 at indx0 -> cmds 16'h27F1 then 16'h3BF2.
//     move=8'h08 -> 16'h27F1 then 16'h33F2.
//  3) Hold cmd_ack low 10 clks -> cmd_vld and cmd steady for all 10.
//     Pulse leg_done during YCMD -> ignored; FSM still waits in YWAIT.
//  4) move=8'h03 at indx5 -> err pulses once, no cmd_vld for that indx, busy=0, indx=0.
//     move=8'h00 behaves the same.
//  5) Assert rst during XWAIT of indx 12 -> all outputs 0 asynchronously.
//     A fresh start restarts from indx 0.
//  6) start pulsed again while busy -> no effect on indx or cmd sequence.

Source files
------------

// File: rtl/tour_move_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tour_move_sequencer
// Reads the solved knight tour and issues each move as a Y leg then an X leg.
// Rev     : 1.0
// ============================================================================
module tour_move_sequencer #(
  parameter int         NUM_MOVES = 24,
  parameter logic [3:0] MOVE_OP   = 4'h2,
  parameter logic [3:0] FANF_OP   = 4'h3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [4:0]  indx,
  input  logic [7:0]  move,
  output logic [15:0] cmd,
  output logic        cmd_vld,
  input  logic        cmd_ack,
  input  logic        leg_done,
  output logic        busy,
  output logic        tour_done,
  output logic        err
);

  localparam logic [7:0] HDG_PY    = 8'h00;
  localparam logic [7:0] HDG_MX    = 8'h3F;
  localparam logic [7:0] HDG_MY    = 8'h7F;
  localparam logic [7:0] HDG_PX    = 8'hBF;
  localparam logic [4:0] LAST_INDX = 5'(NUM_MOVES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    YCMD  = 3'd2,
    YWAIT = 3'd3,
    XCMD  = 3'd4,
    XWAIT = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  indx_q, indx_d;
  logic [15:0] cmd_q, cmd_d;
  logic        cmd_vld_q, cmd_vld_d;
  logic        tour_done_q, tour_done_d;
  logic        err_q, err_d;
  logic [7:0]  move_q, move_d;

  logic        y_ok;
  logic [11:0] y_leg;
  logic [11:0] x_leg;

  // {valid, heading, squares}; only a one-hot move decodes as valid
  function automatic logic [12:0] y_leg_of(input logic [7:0] m);
    case (m)
      8'h01, 8'h02: y_leg_of = {1'b1, HDG_PY, 4'd2};
      8'h04, 8'h40: y_leg_of = {1'b1, HDG_PY, 4'd1};
      8'h08, 8'h80: y_leg_of = {1'b1, HDG_MY, 4'd1};
      8'h10, 8'h20: y_leg_of = {1'b1, HDG_MY, 4'd2};
      default:      y_leg_of = 13'd0;
    endcase
  endfunction

  function automatic logic [11:0] x_leg_of(input logic [7:0] m);
    case (m)
      8'h01, 8'h10: x_leg_of = {HDG_MX, 4'd1};
      8'h02, 8'h20: x_leg_of = {HDG_PX, 4'd1};
      8'h04, 8'h08: x_leg_of = {HDG_MX, 4'd2};
      8'h40, 8'h80: x_leg_of = {HDG_PX, 4'd2};
      default:      x_leg_of = 12'd0;
    endcase
  endfunction

  assign {y_ok, y_leg} = y_leg_of(move);
  assign x_leg         = x_leg_of(move_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      indx_q      <= 5'd0;
      cmd_q       <= 16'd0;
      cmd_vld_q   <= 1'b0;
      tour_done_q <= 1'b0;
      err_q       <= 1'b0;
      move_q      <= 8'd0;
    end else begin
      state_q     <= state_d;
      indx_q      <= indx_d;
      cmd_q       <= cmd_d;
      cmd_vld_q   <= cmd_vld_d;
      tour_done_q <= tour_done_d;
      err_q       <= err_d;
      move_q      <= move_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    indx_d      = indx_q;
    cmd_d       = cmd_q;
    cmd_vld_d   = cmd_vld_q;
    tour_done_d = 1'b0;
    err_d       = 1'b0;
    move_d      = move_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          indx_d  = 5'd0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        move_d = move;
        if (!y_ok) begin
          err_d   = 1'b1;
          indx_d  = 5'd0;
          state_d = IDLE;
        end else begin
          cmd_d     = {MOVE_OP, y_leg};
          cmd_vld_d = 1'b1;
          state_d   = YCMD;
        end
      end
      YCMD: begin
        // a leg_done coinciding with the ack belongs to no issued leg yet
        if (cmd_ack) begin
          cmd_vld_d = 1'b0;
          state_d   = YWAIT;
        end
      end
      YWAIT: begin
        if (leg_done) begin
          cmd_d     = {FANF_OP, x_leg};
          cmd_vld_d = 1'b1;
          state_d   = XCMD;
        end
      end
      XCMD: begin
        if (cmd_ack) begin
          cmd_vld_d = 1'b0;
          state_d   = XWAIT;
        end
      end
      XWAIT: begin
        if (leg_done) begin
          if (indx_q == LAST_INDX) begin
            tour_done_d = 1'b1;
            indx_d      = 5'd0;
            state_d     = IDLE;
          end else begin
            indx_d  = indx_q + 5'd1;
            state_d = LOAD;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        indx_d    = 5'd0;
        cmd_vld_d = 1'b0;
      end
    endcase
  end

  assign indx      = indx_q;
  assign cmd       = cmd_q;
  assign cmd_vld   = cmd_vld_q;
  assign tour_done = tour_done_q;
  assign err       = err_q;
  assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_tour_move_sequencer.sv
`default_nettype none
// Random knight tours scored against a move-table model; a responder plays the
// motion controller and a monitor pops expected events as the DUT emits them.
module tb_tour_move_sequencer;

  localparam int K_CMD  = 0;
  localparam int K_DONE = 1;
  localparam int K_ERR  = 2;

  typedef struct {
    int          kind;
    logic [15:0] cmd;
    int          idx;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        cmd_ack = 1'b0;
  logic        leg_done = 1'b0;
  logic [4:0]  indx;
  logic [7:0]  move;
  logic [15:0] cmd;
  logic        cmd_vld, busy, tour_done, err;

  logic [7:0]  tab [0:31];
  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          trig_cyc = 0;
  bit          outstanding = 0;
  bit          fixed_dly = 0, hold_mode = 0, spur_mode = 0, both_mode = 0;
  bit          long_done = 0, pester = 0;
  logic        prev_vld = 1'b0;
  logic [15:0] cur_cmd = 16'd0;

  // Knight offsets (dx, dy) by move bit number
  int DX[8] = '{-1,  1, -2, -2, -1,  1,  2,  2};
  int DY[8] = '{ 2,  2,  1, -1, -2, -2,  1, -1};

  tour_move_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .indx      (indx),
    .move      (move),
    .cmd       (cmd),
    .cmd_vld   (cmd_vld),
    .cmd_ack   (cmd_ack),
    .leg_done  (leg_done),
    .busy      (busy),
    .tour_done (tour_done),
    .err       (err)
  );

  assign move = tab[indx];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: condition not reached (cycle %0d)", name, cyc);
  endtask

  function automatic logic [15:0] leg(input logic [3:0] op, input int d, input bit is_x);
    logic [7:0] h;
    if (is_x) h = (d > 0) ? 8'hBF : 8'h3F;
    else      h = (d > 0) ? 8'h00 : 8'h7F;
    return {op, h, 4'(d < 0 ? -d : d)};
  endfunction

  task automatic push_exp(input int kind, input logic [15:0] c, input int idx, input int lat);
    exp_t e;
    e.kind = kind; e.cmd = c; e.idx = idx; e.lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic model_tour();
    for (int i = 0; i < 24; i++) begin
      int b;
      b = 0;
      if ($countones(tab[i]) != 1) begin
        push_exp(K_ERR, 16'd0, 0, 2);
        return;
      end
      for (int k = 0; k < 8; k++) if (tab[i][k]) b = k;
      push_exp(K_CMD, leg(4'h2, DY[b], 1'b0), i, 2);
      push_exp(K_CMD, leg(4'h3, DX[b], 1'b1), i, 1);
    end
    push_exp(K_DONE, 16'd0, 0, 1);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 32; i++) tab[i] = 8'(1 << $urandom_range(0, 7));
  endtask

  task automatic observe(input int kind);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL unexpected_output: kind %0d cmd %h indx %0d, expected nothing", kind, cmd, indx);
      return;
    end
    e = exp_q.pop_front();
    chk("event_kind", kind, e.kind);
    chk("latency", cyc - trig_cyc, e.lat);
    if (kind == K_CMD) begin
      chk("cmd", cmd, e.cmd);
      chk("indx", indx, e.idx);
      chk("leg_pending", outstanding, 0);
      cur_cmd = e.cmd;
    end else begin
      chk("busy_at_end", busy, 0);
      chk("indx_at_end", indx, 0);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (cmd_vld && !prev_vld) observe(K_CMD);
      else if (cmd_vld)         chk("cmd_hold", cmd, cur_cmd);
      if (tour_done) observe(K_DONE);
      if (err)       observe(K_ERR);
    end
    prev_vld = cmd_vld;
  end

  // Motion-controller responder
  initial begin
    int a, d;
    forever begin
      @(negedge clk);
      if (cmd_vld && !rst) begin
        if (fixed_dly)                                a = 1;
        else if (hold_mode && $urandom_range(0, 3) == 0) a = 10;
        else                                          a = $urandom_range(0, 3);
        for (int k = 0; k < a; k++) begin
          leg_done = (spur_mode && k == 4);
          @(negedge clk);
        end
        leg_done = both_mode && ($urandom_range(0, 1) == 1);
        cmd_ack  = 1'b1;
        @(negedge clk);
        cmd_ack     = 1'b0;
        leg_done    = 1'b0;
        outstanding = 1;
        d = fixed_dly ? 3 : (long_done ? 8 : $urandom_range(1, 4));
        repeat (d - 1) @(negedge clk);
        leg_done    = 1'b1;
        outstanding = 0;
        trig_cyc    = cyc;
        @(negedge clk);
        leg_done = 1'b0;
      end
    end
  end

  task automatic start_tour();
    model_tour();
    @(negedge clk);
    start    = 1'b1;
    trig_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_tour();
    int k;
    for (k = 0; k < 6000; k++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) break;
      if (pester && busy && $urandom_range(0, 30) == 0) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
    if (k == 6000) fail_now("tour_timeout");
    repeat (2) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_indx", indx, 0);
    chk("idle_vld", cmd_vld, 0);
  endtask

  task automatic run_tour();
    start_tour();
    wait_tour();
  endtask

  initial begin
    int k;
    fill_random();
    repeat (3) @(negedge clk);
    chk("reset_cmd", cmd, 0);
    chk("reset_vld", cmd_vld, 0);
    chk("reset_busy", busy, 0);
    chk("reset_indx", indx, 0);
    chk("reset_done", tour_done, 0);
    chk("reset_err", err, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Uniform tour with fixed handshake timing
    for (int i = 0; i < 32; i++) tab[i] = 8'h01;
    fixed_dly = 1;
    run_tour();
    fixed_dly = 0;

    // Specific moves at the head of a random tour
    fill_random();
    tab[0] = 8'h80;
    tab[1] = 8'h08;
    run_tour();

    // Long ack stalls with stray leg_done while a command is pending
    fill_random();
    hold_mode = 1; spur_mode = 1;
    run_tour();
    hold_mode = 0; spur_mode = 0;

    // leg_done arriving together with the ack
    fill_random();
    both_mode = 1;
    run_tour();
    both_mode = 0;

    // Non one-hot moves abort the tour
    fill_random();
    tab[5] = 8'h03;
    run_tour();
    fill_random();
    tab[$urandom_range(0, 23)] = 8'h00;
    run_tour();

    // Asynchronous reset while waiting on the X leg of move 12
    fill_random();
    long_done = 1;
    start_tour();
    for (k = 0; k < 6000; k++) begin
      @(negedge clk);
      if (outstanding && indx == 5'd12 && cmd[15:12] == 4'h3) break;
    end
    if (k == 6000) fail_now("reach_xwait_12");
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_cmd", cmd, 0);
    chk("arst_vld", cmd_vld, 0);
    chk("arst_busy", busy, 0);
    chk("arst_indx", indx, 0);
    chk("arst_done", tour_done, 0);
    chk("arst_err", err, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (!outstanding) break;
    end
    long_done = 0;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", busy, 0);
    fill_random();
    run_tour();

    // Redundant start pulses while busy
    fill_random();
    pester = 1;
    run_tour();
    fill_random();
    run_tour();
    pester = 0;

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
